// File: rtl/memref_tb_pkg.sv
// Shared types and default sizes for the memref fill/dump driver and the
// memref_rd/memref_wr memory models.
package memref_tb_pkg;

    localparam int unsigned MEMREF_WIDTH = 32;
    localparam int unsigned MEMREF_SIZE  = 64;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StKick,
        StWait,
        StDump,
        StDone
    } state_e;

endpackage

// File: rtl/memref_fill_dump.sv
// Initiator for the single-port memref protocol: fills memory with a base+index pattern,
// kicks the kernel, waits for completion or timeout, then dumps memory into a checksum.
module memref_fill_dump
    import memref_tb_pkg::*;
#(
    parameter int unsigned WIDTH   = MEMREF_WIDTH,
    parameter int unsigned SIZE    = MEMREF_SIZE,
    parameter int unsigned ADDR_W  = $clog2(SIZE),
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  fill_base,
    input  logic              patch_en,
    input  logic [ADDR_W-1:0] patch_addr,
    input  logic [WIDTH-1:0]  patch_data,
    output logic              kernel_start,
    input  logic              kernel_done,
    output logic              mem_own,
    output logic [ADDR_W-1:0] mem_addr_data,
    output logic              mem_addr_en,
    output logic              mem_wr_en,
    output logic [WIDTH-1:0]  mem_wr_data,
    output logic              mem_rd_en,
    input  logic [WIDTH-1:0]  mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [WIDTH-1:0]  checksum
);

    // One extra index bit so the dump drain cycle (index == SIZE) is representable.
    localparam int unsigned IDX_W  = ADDR_W + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SIZE - 1);
    localparam logic [IDX_W-1:0]  DRAIN_IDX = IDX_W'(SIZE);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               timeout_q, timeout_d;
    logic               rd_pend_q;
    logic               latch_cfg;

    logic [WIDTH-1:0]   base_q;
    logic               patch_en_q;
    logic [ADDR_W-1:0]  patch_addr_q;
    logic [WIDTH-1:0]   patch_data_q;

    logic               patch_hit;
    logic [WIDTH-1:0]   fill_word;

    assign patch_hit = patch_en_q && ({1'b0, patch_addr_q} == idx_q);
    assign fill_word = patch_hit ? patch_data_q : base_q + WIDTH'(idx_q);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wait_d        = wait_q;
        acc_d         = acc_q;
        timeout_d     = timeout_q;
        latch_cfg     = 1'b0;
        kernel_start  = 1'b0;
        mem_own       = 1'b0;
        mem_addr_data = '0;
        mem_addr_en   = 1'b0;
        mem_wr_en     = 1'b0;
        mem_wr_data   = '0;
        mem_rd_en     = 1'b0;
        done          = 1'b0;

        // Read data returns one cycle after each issue; fold it in as it arrives.
        if (rd_pend_q) begin
            acc_d = acc_q + mem_rd_data;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StFill;
                    idx_d     = '0;
                    acc_d     = '0;
                    timeout_d = 1'b0;
                    latch_cfg = 1'b1;
                end
            end
            StFill: begin
                mem_own       = 1'b1;
                mem_addr_data = idx_q[ADDR_W-1:0];
                mem_addr_en   = 1'b1;
                mem_wr_en     = 1'b1;
                mem_wr_data   = fill_word;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = StKick;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StKick: begin
                kernel_start = 1'b1;
                wait_d       = '0;
                state_d      = StWait;
            end
            StWait: begin
                if (kernel_done) begin
                    state_d = StDump;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = StDump;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDump: begin
                mem_own = 1'b1;
                if (idx_q == DRAIN_IDX) begin
                    state_d = StDone;
                end else begin
                    mem_addr_data = idx_q[ADDR_W-1:0];
                    mem_addr_en   = 1'b1;
                    mem_rd_en     = 1'b1;
                    idx_d         = idx_q + 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            wait_q       <= '0;
            acc_q        <= '0;
            timeout_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            base_q       <= '0;
            patch_en_q   <= 1'b0;
            patch_addr_q <= '0;
            patch_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            acc_q     <= acc_d;
            timeout_q <= timeout_d;
            rd_pend_q <= mem_rd_en;
            if (latch_cfg) begin
                base_q       <= fill_base;
                patch_en_q   <= patch_en;
                patch_addr_q <= patch_addr;
                patch_data_q <= patch_data;
            end
        end
    end

    assign busy     = (state_q != StIdle);
    assign timeout  = timeout_q;
    assign checksum = acc_q;

endmodule
